// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matching engine and its job loader.
// Pure declarations: no logic, no latency, no flow control.
package sme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_WAIT,
        ST_RESULT
    } loader_state_t;

    localparam int SME_STR_MAX = 32;
    localparam int SME_PAT_MAX = 8;

    localparam logic [7:0] SME_CH_BEGIN = 8'h5E;
    localparam logic [7:0] SME_CH_END   = 8'h24;
    localparam logic [7:0] SME_CH_DOT   = 8'h2E;
    localparam logic [7:0] SME_CH_SPACE = 8'h20;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Byte buffer with saturating append pointer, sticky overflow flag and combinational indexed read.
// Write takes effect at the next edge; writes past DEPTH are dropped and raise ovf.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = len_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_dat,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_dat,
    output logic [LW-1:0] len,
    output logic          ovf
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [LW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          full;

    assign full = (len_q == LW'(DEPTH));

    always_comb begin
        mem_d = mem_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (clr) begin
            len_d = '0;
            ovf_d = 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[len_q[AW-1:0]] = wr_dat;
                len_d                = len_q + LW'(1);
            end
        end
    end

    // Storage is deliberately left out of reset; only the pointer and flag clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!reset) begin
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    assign rd_dat = mem_q[rd_idx];
    assign len    = len_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/sme_job_loader.sv
// Buffers a host job (string then pattern bytes), replays it to SME as one isstring then one ispattern burst, returns match/index.
// Burst begins the 2nd edge after the last pattern byte; in_ready only in COLLECT; result held until res_ready. SME_LOADER_TIMEOUT_EN bounds WAIT.
module sme_job_loader
    import sme_pkg::*;
#(
    parameter int STR_MAX = SME_STR_MAX,
    parameter int PAT_MAX = SME_PAT_MAX,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_err
);

    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int SLW = len_w(STR_MAX);
    localparam int PLW = len_w(PAT_MAX);

    loader_state_t  state_q, state_d;
    logic [SLW-1:0] rd_q, rd_d;
    logic           seen_pat_q, seen_pat_d;
    logic           err_q, err_d;
    logic           in_ready_q, in_ready_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           res_valid_q, res_valid_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           res_err_q, res_err_d;
`ifdef SME_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  tmo_q, tmo_d;
`endif

    logic           xfer, job_end, buf_clr, str_we, pat_we;
    logic [7:0]     str_rd, pat_rd;
    logic [SLW-1:0] str_len;
    logic [PLW-1:0] pat_len;
    logic           str_ovf, pat_ovf;

    assign xfer    = in_valid && in_ready_q;
    assign job_end = xfer && in_kind && in_last;
    assign buf_clr = (state_q == ST_IDLE);
    assign str_we  = xfer && !in_kind && !seen_pat_q;
    assign pat_we  = xfer && in_kind;

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (buf_clr),
        .wr_en  (str_we),
        .wr_dat (in_data),
        .rd_idx (rd_q[SAW-1:0]),
        .rd_dat (str_rd),
        .len    (str_len),
        .ovf    (str_ovf)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (buf_clr),
        .wr_en  (pat_we),
        .wr_dat (in_data),
        .rd_idx (rd_q[PAW-1:0]),
        .rd_dat (pat_rd),
        .len    (pat_len),
        .ovf    (pat_ovf)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        seen_pat_d  = seen_pat_q;
        err_d       = err_q;
        in_ready_d  = 1'b0;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        chardata_d  = 8'h00;
        res_valid_d = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        res_err_d   = res_err_q;
`ifdef SME_LOADER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                seen_pat_d = 1'b0;
                err_d      = 1'b0;
                rd_d       = '0;
                state_d    = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready_d = !job_end;
                rd_d       = '0;
                if (xfer && in_kind) seen_pat_d = 1'b1;
                if (xfer && !in_kind && seen_pat_q) err_d = 1'b1;
                if (job_end) state_d = (str_len != '0) ? ST_SEND_STR : ST_SEND_PAT;
            end
            ST_SEND_STR: begin
                isstring_d = 1'b1;
                chardata_d = str_rd;
                if (rd_q + SLW'(1) == str_len) begin
                    rd_d    = '0;
                    state_d = ST_SEND_PAT;
                end else begin
                    rd_d = rd_q + SLW'(1);
                end
            end
            ST_SEND_PAT: begin
                ispattern_d = 1'b1;
                chardata_d  = pat_rd;
                if (rd_q + SLW'(1) == SLW'(pat_len)) begin
                    rd_d    = '0;
                    state_d = ST_WAIT;
`ifdef SME_LOADER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    rd_d = rd_q + SLW'(1);
                end
            end
            ST_WAIT: begin
                if (sme_valid) begin
                    res_match_d = sme_match;
                    res_index_d = sme_index;
                    res_err_d   = err_q || str_ovf || pat_ovf;
                    state_d     = ST_RESULT;
                end
`ifdef SME_LOADER_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    res_match_d = 1'b0;
                    res_index_d = 5'd0;
                    res_err_d   = 1'b1;
                    state_d     = ST_RESULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            ST_RESULT: begin
                // res_valid rises one cycle after entry, so a handshake needs the registered flag.
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            seen_pat_q  <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            chardata_q  <= 8'h00;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
            res_err_q   <= 1'b0;
`ifdef SME_LOADER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            seen_pat_q  <= seen_pat_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            chardata_q  <= chardata_d;
            res_valid_q <= res_valid_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            res_err_q   <= res_err_d;
`ifdef SME_LOADER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign chardata  = chardata_q;
    assign res_valid = res_valid_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_sme_job_loader.sv
// Scoreboard bench for sme_job_loader: host jobs queue expected burst bytes and results, an SME stub replies.
// Outputs are sampled and inputs driven on the falling edge.
module tb_sme_job_loader;

    localparam int S_MAX = 32;
    localparam int P_MAX = 8;

    typedef struct packed {
        logic [7:0] dat;
        logic       kind;
        logic       last;
    } stim_t;

    typedef struct packed {
        logic       m;
        logic [4:0] idx;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_kind = 1'b0;
    logic       in_last = 1'b0;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_index = 5'd0;
    logic       res_ready = 1'b0;
    logic       in_ready, isstring, ispattern, res_valid, res_match, res_err;
    logic [7:0] chardata;
    logic [4:0] res_index;

    int checks = 0;
    int errors = 0;

    stim_t      stim_q[$];
    logic [7:0] exp_str_q[$];
    logic [7:0] exp_pat_q[$];
    res_t       exp_res_q[$];
    int         m_str_n, m_pat_n;
    bit         m_seen, m_err;

    always #5 clk = ~clk;

    sme_job_loader #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_kind   (in_kind),
        .in_last   (in_last),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .sme_match (sme_match),
        .sme_index (sme_index),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_index (res_index),
        .res_err   (res_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {13'd0, in_ready, isstring, ispattern, res_valid, res_match, res_err, res_index, chardata};
    endfunction

    function automatic logic [7:0] res_vec();
        return {res_valid, res_match, res_err, res_index};
    endfunction

    task automatic start_job();
        m_str_n = 0;
        m_pat_n = 0;
        m_seen  = 1'b0;
        m_err   = 1'b0;
        exp_str_q.delete();
        exp_pat_q.delete();
    endtask

    // Host byte plus the reference model of what the loader must keep and send.
    task automatic add_byte(input logic kind, input logic [7:0] dat, input logic last);
        stim_t b;
        b.dat  = dat;
        b.kind = kind;
        b.last = last;
        stim_q.push_back(b);
        if (!kind) begin
            if (m_seen || m_str_n >= S_MAX) m_err = 1'b1;
            else begin
                exp_str_q.push_back(dat);
                m_str_n++;
            end
        end else begin
            m_seen = 1'b1;
            if (m_pat_n >= P_MAX) m_err = 1'b1;
            else begin
                exp_pat_q.push_back(dat);
                m_pat_n++;
            end
        end
    endtask

    task automatic add_seg(input logic kind, input string txt, input bit closes);
        for (int i = 0; i < txt.len(); i++)
            add_byte(kind, txt[i], closes && (i == txt.len() - 1));
    endtask

    task automatic drive_stim(input bit noise);
        int    stalls = 0;
        int    wait_n;
        bit    first = 1'b1;
        stim_t b;
        if (noise) begin
            sme_valid = 1'b1;
            sme_match = 1'b1;
            sme_index = 5'd31;
        end
        while (stim_q.size() > 0) begin
            b        = stim_q.pop_front();
            in_valid = 1'b1;
            in_data  = b.dat;
            in_kind  = b.kind;
            in_last  = b.last;
            wait_n   = 0;
            while (!in_ready && wait_n < 50) begin
                @(negedge clk);
                wait_n++;
            end
            if (wait_n >= 50) begin
                check_eq("in_ready_wait", 32'(wait_n), 32'd0);
                stim_q.delete();
                break;
            end
            if (!first) stalls += wait_n;
            first = 1'b0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sme_valid = 1'b0;
        sme_match = 1'b0;
        sme_index = 5'd0;
        check_eq("in_ready_stalls", 32'(stalls), 32'd0);
    endtask

    task automatic check_burst();
        int n_s = exp_str_q.size();
        int n_p = exp_pat_q.size();
        int lat = 0;
        int cs = 0;
        int cp = 0;
        int guard = 0;
        bit both = 1'b0;
        bit bad_order = 1'b0;
        while (!(isstring || ispattern) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check_eq("burst_latency", 32'(lat), 32'd1);
        while ((isstring || ispattern) && guard < 64) begin
            if (isstring && ispattern) both = 1'b1;
            if (isstring) begin
                if (cp > 0) bad_order = 1'b1;
                cs++;
                if (exp_str_q.size() > 0) check_eq("str_byte", 32'(chardata), 32'(exp_str_q.pop_front()));
            end else begin
                cp++;
                if (exp_pat_q.size() > 0) check_eq("pat_byte", 32'(chardata), 32'(exp_pat_q.pop_front()));
            end
            @(negedge clk);
            guard++;
        end
        check_eq("str_count", 32'(cs), 32'(n_s));
        check_eq("pat_count", 32'(cp), 32'(n_p));
        check_eq("burst_shape", {30'd0, both, bad_order}, 32'd0);
    endtask

    task automatic finish_job(input logic m, input logic [4:0] idx, input bit stub_replies, input int hold);
        res_t       r;
        int         lat = 0;
        logic [7:0] snap;
        if (stub_replies) begin
            exp_res_q.push_back('{m, idx, m_err});
            @(negedge clk);
            sme_valid = 1'b1;
            sme_match = m;
            sme_index = idx;
            @(negedge clk);
            sme_valid = 1'b0;
            sme_match = 1'b0;
            sme_index = 5'd0;
            check_eq("res_valid_early", 32'(res_valid), 32'd0);
        end else begin
            exp_res_q.push_back('{1'b0, 5'd0, 1'b1});
        end
        while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (stub_replies) check_eq("res_latency", 32'(lat), 32'd1);
        else check_eq("timeout_result", 32'(res_valid), 32'd1);
        r = exp_res_q.pop_front();
        check_eq("res_match", 32'(res_match), 32'(r.m));
        check_eq("res_index", 32'(res_index), 32'(r.idx));
        check_eq("res_err", 32'(res_err), 32'(r.err));
        snap = res_vec();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("res_hold", {23'd0, res_vec(), in_ready}, {23'd0, snap, 1'b0});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("post_hs_k0", {30'd0, res_valid, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("post_hs_k1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("post_hs_k2", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 32'd0);
        reset = 1'b1;

        start_job();
        add_seg(1'b0, "ab cd", 1'b1);
        add_seg(1'b1, "cd", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b1, 5'd3, 1'b1, 10);

        // sme_valid raised while collecting must not produce a result
        start_job();
        add_seg(1'b1, "^ab$", 1'b1);
        drive_stim(1'b1);
        check_burst();
        finish_job(1'b0, 5'd0, 1'b1, 0);

        start_job();
        for (int i = 0; i < 40; i++) add_byte(1'b0, 8'(65 + i), i == 39);
        add_seg(1'b1, "AB", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b1, 5'd7, 1'b1, 2);

        start_job();
        add_seg(1'b0, "xy", 1'b1);
        add_seg(1'b1, "0123456789", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b0, 5'd0, 1'b1, 0);

        start_job();
        add_seg(1'b0, "abc", 1'b1);
        add_seg(1'b1, "a", 1'b0);
        add_seg(1'b0, "z", 1'b1);
        add_seg(1'b1, "b", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b1, 5'd1, 1'b1, 0);

        start_job();
        add_seg(1'b0, "hello world", 1'b1);
        add_seg(1'b1, "wo", 1'b1);
        drive_stim(1'b0);
        lat = 0;
        while (!isstring && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check_eq("mid_burst_start", 32'(isstring), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_outputs", out_vec(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_quiet", {30'd0, isstring, ispattern}, 32'd0);

        start_job();
        add_seg(1'b0, "abcd", 1'b1);
        add_seg(1'b1, "$b.", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b1, 5'd2, 1'b1, 0);

`ifdef SME_LOADER_TIMEOUT_EN
        start_job();
        add_seg(1'b1, "q", 1'b1);
        drive_stim(1'b0);
        check_burst();
        finish_job(1'b0, 5'd0, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
